ixu_alu_arbiter: RTL

Shares one combinational integer ALU (ADD..SLTU, op codes 0x0-0x9) between NUM_REQ VLIW issue slots using round-robin arbitration.
- Each slot presents a fully decoded integer op with a valid/ready handshake.
- The arbiter drives the ALU with the winning op and registers the result into a one-entry response buffer, tagged with the winning slot id.
- The block sits between the issue stage and writeback in the IXU.

---
 rtl/ixu_alu_arbiter_if.sv | 54 +++++
 rtl/ixu_alu_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/ixu_alu_arbiter_if.sv
// Bus bundle between the issue slots, the shared integer ALU, the
// arbiter and the writeback consumer. The arbiter uses the slave
// modport. The surrounding logic (issue, ALU, writeback) uses master.
interface ixu_alu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    // Issue-slot request side. Slot i occupies [W*i +: W] in each vector.
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_rs1_data;
    logic [NUM_REQ*32-1:0] req_rs2_data;
    logic [NUM_REQ*12-1:0] req_imm;
    logic [NUM_REQ-1:0]    req_is_imm_type;
    logic [NUM_REQ*4-1:0]  req_op;

    // Shared combinational ALU.
    logic [31:0] alu_rs1_data;
    logic [31:0] alu_rs2_data;
    logic [11:0] alu_imm;
    logic        alu_is_imm_type;
    logic        alu_is_nop;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;

    // One-entry response buffer toward writeback.
    logic            rsp_valid;
    logic            rsp_ready;
    logic [ID_W-1:0] rsp_id;
    logic [31:0]     rsp_data;
    logic            rsp_err;

    modport slave (
        input  req_valid, req_rs1_data, req_rs2_data, req_imm,
               req_is_imm_type, req_op,
        output req_ready,
        output alu_rs1_data, alu_rs2_data, alu_imm, alu_is_imm_type,
               alu_is_nop, alu_op,
        input  alu_out,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_rs1_data, req_rs2_data, req_imm,
               req_is_imm_type, req_op,
        input  req_ready,
        input  alu_rs1_data, alu_rs2_data, alu_imm, alu_is_imm_type,
               alu_is_nop, alu_op,
        output alu_out,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/ixu_alu_arbiter.sv
// Round-robin arbiter that shares one combinational integer ALU among
// NUM_REQ issue slots. The winning op drives the ALU. Its result is
// captured into a one-entry response buffer that is tagged with the slot id.
module ixu_alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    ixu_alu_arbiter_if.slave bus
);
    // Split the packed request vectors into one array entry per slot.
    logic [31:0] rs1_arr  [NUM_REQ];
    logic [31:0] rs2_arr  [NUM_REQ];
    logic [11:0] imm_arr  [NUM_REQ];
    logic [3:0]  op_arr   [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        assign rs1_arr[g] = bus.req_rs1_data[32*g +: 32];
        assign rs2_arr[g] = bus.req_rs2_data[32*g +: 32];
        assign imm_arr[g] = bus.req_imm[12*g +: 12];
        assign op_arr[g]  = bus.req_op[4*g +: 4];
    end

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    logic            can_issue;
    logic            found;
    logic            grant;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;

    // Buffer is free when empty or being drained this cycle. This path
    // carries rsp_ready into req_ready and is allowed.
    assign can_issue = !rsp_valid_q || bus.rsp_ready;

    // Round-robin scan: take the first valid slot at or after rr_ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Gating with rst_n holds req_ready at 0 and keeps the ALU idle
    // while reset is asserted, even though the buffer reads as empty.
    assign grant = found && can_issue && rst_n;

    // One-hot grant to the winning slot.
    always_comb begin
        bus.req_ready = '0;
        if (grant) begin
            bus.req_ready[win] = 1'b1;
        end
    end

    // ALU operand mux. When there is no grant, drive zeros so the ALU inputs do not toggle.
    always_comb begin
        bus.alu_rs1_data    = '0;
        bus.alu_rs2_data    = '0;
        bus.alu_imm         = '0;
        bus.alu_is_imm_type = 1'b0;
        bus.alu_is_nop      = 1'b1;
        bus.alu_op          = '0;
        if (grant) begin
            bus.alu_rs1_data    = rs1_arr[win];
            bus.alu_rs2_data    = rs2_arr[win];
            bus.alu_imm         = imm_arr[win];
            bus.alu_is_imm_type = bus.req_is_imm_type[win];
            bus.alu_is_nop      = 1'b0;
            bus.alu_op          = op_arr[win];
        end
    end

    // Next state for the response buffer and the rotation pointer.
    // A grant overwrites the buffer, and that also covers a drain in the
    // same cycle. A drain with no grant clears only the valid bit.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (grant) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = win;
            rsp_data_d  = bus.alu_out;
            rsp_err_d   = (bus.alu_op > 4'h9);
            rr_ptr_d    = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers. Reset discards any result still in the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
